// File: rtl/arrow_sequence_gen.sv
// Arrow event generator: a divider paces events, each pushing an LFSR or sensor arrow into a lookahead FIFO.
// Optional macro ARROW_GEN_REPEAT_FILTER_EN rotates a random arrow that repeats the last pushed one.
module arrow_sequence_gen #(
  parameter int                ARROW_W  = 5,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] TAPS     = 16'hB400,
  parameter int                TICK_DIV = 25000000,
  parameter int                DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         seed_load,
  input  logic [LFSR_W-1:0]            seed,
  input  logic [ARROW_W-1:0]           gsensor,
  output logic                         tick,
  output logic [ARROW_W-1:0]           arrow_data,
  output logic                         arrow_valid,
  input  logic                         arrow_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [ARROW_W-1:0] nonzero_arrow(input logic [ARROW_W-1:0] a);
    return (a == '0) ? ARROW_W'(1) : a;
  endfunction

  function automatic logic [ARROW_W-1:0] rotl1(input logic [ARROW_W-1:0] a);
    return (a << 1) | (a >> (ARROW_W - 1));
  endfunction

  logic [CNT_W-1:0]   r_cnt;
  logic               r_tick;
  logic [LFSR_W-1:0]  r_lfsr;
  logic [ARROW_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_overflow;

  logic               w_event;
  logic [LFSR_W-1:0]  w_lfsr_next;
  logic [ARROW_W-1:0] w_rand_cand;
  logic [ARROW_W-1:0] w_cand;
  logic               w_valid;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_wr;

  assign w_event     = (r_cnt == CNT_W'(TICK_DIV - 1));
  assign w_lfsr_next = lfsr_advance(r_lfsr);
  assign w_rand_cand = nonzero_arrow(w_lfsr_next[ARROW_W-1:0]);
  assign w_valid     = (r_level != '0);
  assign w_full      = (r_level == LVL_W'(DEPTH));
  assign w_pop       = w_valid & arrow_ready;
  assign w_push      = w_event & ~seed_load;
  // A full queue still accepts the push when the head leaves in the same cycle.
  assign w_wr        = w_push & (~w_full | w_pop);

`ifdef ARROW_GEN_REPEAT_FILTER_EN
  logic [ARROW_W-1:0] r_last;

  always_comb begin
    w_cand = gsensor;
    if (!mode) begin
      w_cand = (w_rand_cand == r_last) ? rotl1(w_rand_cand) : w_rand_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || seed_load) begin
      r_last <= '0;
    end else if (w_wr) begin
      r_last <= w_cand;
    end
  end
`else
  assign w_cand = mode ? gsensor : w_rand_cand;
`endif

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_cand;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_lfsr     <= LFSR_W'(1);
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (seed_load) begin
      r_cnt      <= '0;
      r_tick     <= 1'b0;
      r_lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_tick <= w_event;
      r_cnt  <= w_event ? '0 : r_cnt + CNT_W'(1);
      if (w_event) begin
        r_lfsr <= w_lfsr_next;
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign tick        = r_tick;
  assign arrow_valid = w_valid;
  assign arrow_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign level       = r_level;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_arrow_sequence_gen.sv
// Self-checking bench for arrow_sequence_gen (TICK_DIV=4, DEPTH=4) with a queue-based reference model.
module tb_arrow_sequence_gen;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [4:0]  gsensor;
  logic        tick;
  logic [4:0]  arrow_data;
  logic        arrow_valid;
  logic        arrow_ready;
  logic [2:0]  level;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_phase;
  logic [4:0]  m_q[$];
  logic        m_ovf;
  logic        m_tick;
  logic [4:0]  m_last;

  arrow_sequence_gen #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .seed_load(seed_load), .seed(seed),
    .gsensor(gsensor), .tick(tick), .arrow_data(arrow_data),
    .arrow_valid(arrow_valid), .arrow_ready(arrow_ready), .level(level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] galois(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic model_edge();
    logic [15:0] nx;
    logic [4:0]  cand;
    bit          ev, pop, full;
    if (rst) begin
      m_lfsr = 16'd1; m_phase = 0; m_q.delete(); m_ovf = 0; m_tick = 0; m_last = 0;
    end else if (seed_load) begin
      m_lfsr = (seed == 0) ? 16'd1 : seed;
      m_phase = 0; m_q.delete(); m_ovf = 0; m_tick = 0; m_last = 0;
    end else begin
      ev   = (m_phase % 4) == 3;
      full = (m_q.size() == 4);
      pop  = (m_q.size() > 0) && arrow_ready;
      m_tick = ev;
      if (pop) void'(m_q.pop_front());
      if (ev) begin
        nx = galois(m_lfsr);
        m_lfsr = nx;
        cand = mode ? gsensor : ((nx[4:0] == 0) ? 5'd1 : nx[4:0]);
`ifdef ARROW_GEN_REPEAT_FILTER_EN
        if (!mode && cand == m_last) cand = {cand[3:0], cand[4]};
`endif
        if (full && !pop) m_ovf = 1;
        else begin
          m_q.push_back(cand);
          m_last = cand;
        end
      end
      m_phase++;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed = s; seed_load = 1'b1;
    clk_step();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk_step(); clk_step();
    rst = 1'b0;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got=%0b want=0", tick); end
    n_checks++; if (arrow_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%0b want=0", arrow_valid); end
    n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
    n_checks++; if (arrow_data !== 5'd0) begin n_fail++; $display("FAIL reset_data got=%h want=0", arrow_data); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0b want=0", overflow); end
  endtask

  task automatic test_seed_sequence();
    mode = 1'b0; arrow_ready = 1'b0;
    do_seed(16'hACE1);
    for (int i = 1; i <= 8; i++) begin
      clk_step();
      n_checks++;
      if (tick !== ((i == 4) || (i == 8))) begin
        n_fail++; $display("FAIL seq_tick cycle=%0d got=%0b want=%0b", i, tick, (i == 4) || (i == 8));
      end
      if (i == 4) begin
        n_checks++; if (level !== 3'd1 || arrow_data !== 5'h10) begin
          n_fail++; $display("FAIL seq_first level=%0d data=%h want level=1 data=10", level, arrow_data); end
      end
    end
    n_checks++; if (level !== 3'd2 || arrow_data !== 5'h10) begin
      n_fail++; $display("FAIL seq_hold level=%0d data=%h want level=2 data=10", level, arrow_data); end
    arrow_ready = 1'b1; clk_step(); arrow_ready = 1'b0;
    n_checks++; if (level !== 3'd1 || arrow_data !== 5'h18) begin
      n_fail++; $display("FAIL seq_second level=%0d data=%h want level=1 data=18", level, arrow_data); end
  endtask

  task automatic test_seed_zero();
    logic [4:0] want2;
`ifdef ARROW_GEN_REPEAT_FILTER_EN
    want2 = 5'd2;
`else
    want2 = 5'd1;
`endif
    mode = 1'b0; arrow_ready = 1'b0;
    do_seed(16'h0000);
    n_checks++; if (level !== 3'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL zero_flush level=%0d ovf=%0b want 0 0", level, overflow); end
    repeat (4) clk_step();
    n_checks++; if (arrow_data !== 5'd1) begin
      n_fail++; $display("FAIL zero_first got=%h want=01", arrow_data); end
    repeat (4) clk_step();
    arrow_ready = 1'b1; clk_step(); arrow_ready = 1'b0;
    n_checks++; if (arrow_data !== want2 || level !== 3'd1) begin
      n_fail++; $display("FAIL zero_second data=%h level=%0d want data=%h level=1", arrow_data, level, want2); end
  endtask

  task automatic test_overflow();
    mode = 1'b1; gsensor = 5'b00101; arrow_ready = 1'b0;
    do_seed(16'h1234);
    for (int i = 1; i <= 24; i++) begin
      clk_step();
      if (i == 16) begin
        n_checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
          n_fail++; $display("FAIL ovf_full level=%0d ovf=%0b want 4 0", level, overflow); end
      end
    end
    n_checks++; if (level !== 3'd4 || overflow !== 1'b1 || arrow_data !== 5'b00101) begin
      n_fail++; $display("FAIL ovf_drop level=%0d ovf=%0b data=%h want 4 1 05", level, overflow, arrow_data); end
  endtask

  task automatic test_full_simul();
    mode = 1'b1; arrow_ready = 1'b0;
    do_seed(16'h0042);
    for (int k = 1; k <= 4; k++) begin
      gsensor = 5'(k);
      repeat (4) clk_step();
    end
    gsensor = 5'd5;
    repeat (3) clk_step();
    arrow_ready = 1'b1; clk_step(); arrow_ready = 1'b0;
    n_checks++; if (level !== 3'd4 || overflow !== 1'b0 || arrow_data !== 5'd2) begin
      n_fail++; $display("FAIL simul level=%0d ovf=%0b data=%h want 4 0 02", level, overflow, arrow_data); end
    for (int k = 2; k <= 5; k++) begin
      n_checks++; if (arrow_data !== 5'(k)) begin
        n_fail++; $display("FAIL order got=%h want=%h", arrow_data, 5'(k)); end
      arrow_ready = 1'b1; clk_step(); arrow_ready = 1'b0;
    end
  endtask

  task automatic test_rst_mid();
    int  first;
    bool_found: begin end
    first = 0;
    mode = 1'b0; arrow_ready = 1'b0;
    do_seed(16'hBEEF);
    repeat (6) clk_step();
    rst = 1'b1; clk_step(); rst = 1'b0;
    n_checks++; if (tick !== 1'b0 || arrow_valid !== 1'b0 || level !== 3'd0 || arrow_data !== 5'd0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid tick=%0b valid=%0b level=%0d data=%h ovf=%0b want all 0",
                         tick, arrow_valid, level, arrow_data, overflow); end
    for (int i = 1; i <= 10; i++) begin
      clk_step();
      if (first == 0 && tick === 1'b1) first = i;
    end
    n_checks++; if (first != 4) begin
      n_fail++; $display("FAIL rst_first_tick got=%0d want=4 (0 means none within bound)", first); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 149) == 0);
      seed_load   = ($urandom_range(0, 39) == 0);
      seed        = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      gsensor     = 5'($urandom);
      arrow_ready = ($urandom_range(0, 2) == 0);
      clk_step();
      n_checks++; if (tick !== m_tick) begin
        n_fail++; $display("FAIL rnd_tick cyc=%0d got=%0b want=%0b", i, tick, m_tick); end
      n_checks++; if (arrow_valid !== (m_q.size() > 0)) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", i, arrow_valid, m_q.size() > 0); end
      n_checks++; if (level !== 3'(m_q.size())) begin
        n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", i, level, m_q.size()); end
      n_checks++; if (arrow_data !== ((m_q.size() > 0) ? m_q[0] : 5'd0)) begin
        n_fail++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, arrow_data, (m_q.size() > 0) ? m_q[0] : 5'd0); end
      n_checks++; if (overflow !== m_ovf) begin
        n_fail++; $display("FAIL rnd_overflow cyc=%0d got=%0b want=%0b", i, overflow, m_ovf); end
    end
    rst = 1'b0; seed_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; seed_load = 1'b0; seed = 16'h0;
    gsensor = 5'h0; arrow_ready = 1'b0;
    test_reset();
    test_seed_sequence();
    test_seed_zero();
    test_overflow();
    test_full_simul();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arrow_sequence_gen.md
ARROW_SEQUENCE_GEN -- requirements
Module: arrow_sequence_gen

Interface
REQ-001 SHALL have parameter ARROW_W, default 5, arrow bit-vector width (one bit per direction).
REQ-002 SHALL have parameter LFSR_W, default 16, pseudo-random register width, at least ARROW_W.
REQ-003 SHALL have parameter TAPS, default 16'hB400, Galois feedback mask of LFSR_W bits.
REQ-004 SHALL have parameter TICK_DIV, default 25000000, clk cycles per arrow event, at least 2.
REQ-005 SHALL have parameter DEPTH, default 4, lookahead queue entries, a power of 2 and at least 2.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port mode, input, 1 bit: 0 selects the random source, 1 selects the sensor source.
REQ-009 SHALL have port seed_load, input, 1 bit: a one-cycle request to load seed.
REQ-010 SHALL have port seed, input, LFSR_W bits: the LFSR seed value.
REQ-011 SHALL have port gsensor, input, ARROW_W bits: the sensor arrow pattern.
REQ-012 SHALL have port tick, output, 1 bit: a one-cycle pulse at each arrow event.
REQ-013 SHALL have port arrow_data, output, ARROW_W bits: the queue head.
REQ-014 SHALL have port arrow_valid, output, 1 bit: the queue is non-empty.
REQ-015 SHALL have port arrow_ready, input, 1 bit: the consumer accepts the head.
REQ-016 SHALL have port level, output, $clog2(DEPTH+1) bits: the current queue occupancy.
REQ-017 SHALL have port overflow, output, 1 bit: sticky flag set when an arrow was dropped.

Function
REQ-018 SHALL run divider cnt 0..TICK_DIV-1, wrap to 0; tick is registered and high the cycle after cnt==TICK_DIV-1.
REQ-019 SHALL compute lfsr_next as (lfsr>>1)^TAPS when lfsr[0]=1 and lfsr>>1 otherwise; lfsr takes lfsr_next in the same cycle cnt==TICK_DIV-1.
REQ-020 SHALL take the random candidate as lfsr_next[ARROW_W-1:0], replaced by 1 when it is zero, so no empty arrow is produced.
REQ-021 SHALL take the sensor candidate as gsensor sampled in the cnt==TICK_DIV-1 cycle; the LFSR still advances in sensor mode.
REQ-022 SHALL push the candidate into the FIFO at that same edge; arrow_valid and level reflect the push the following cycle (latency 1 from event cycle).
REQ-023 SHALL pop the FIFO when arrow_valid and arrow_ready are both high; arrow_data SHALL be the head and SHALL hold stable while valid and not ready.
REQ-024 SHALL, on a push while full with no pop, drop the candidate, set overflow and leave the queue unchanged.
REQ-025 SHALL, on a push while full with a simultaneous pop, perform both, leave level at DEPTH and leave overflow unchanged.
REQ-026 SHALL, on a push and pop both while empty, perform the push only; the pop is ignored since arrow_valid is low.
REQ-027 SHALL implement FIFO pointers as wrapping log2(DEPTH)-bit counters; level SHALL never exceed DEPTH nor underflow.
REQ-028 SHALL, on seed_load, load lfsr with seed (or 1 when seed is zero), clear cnt, flush the FIFO and clear overflow; seed_load SHALL take priority over the event in the same cycle.
REQ-029 SHALL apply a mode change at the next event with no flush.

Reset
REQ-030 SHALL, with rst high at a clk edge, set lfsr=1, cnt=0, tick=0, FIFO empty (arrow_valid=0, level=0, arrow_data=0) and overflow=0; rst SHALL dominate seed_load and the event.
REQ-031 SHALL discard any in-progress divider count when rst is asserted mid-interval; counting SHALL restart from 0 after release.

Configuration
REQ-032 SHALL, with macro ARROW_GEN_REPEAT_FILTER_EN defined, replace a random candidate equal to the last pushed arrow with that candidate rotated left by 1; the last-pushed register SHALL reset to 0 and be cleared by seed_load. Sensor candidates are unfiltered.
REQ-033 SHALL, without ARROW_GEN_REPEAT_FILTER_EN, push candidates unmodified, with no last-pushed register present.

Verification
REQ-034 SHALL verify TICK_DIV=4, seed_load with seed=16'hACE1, mode=0, arrow_ready=0 -> pushes 5'h10 then 5'h18, with tick high every 4th cycle.
REQ-035 SHALL verify seed_load with seed=0 -> lfsr=1, and the first candidate equals 1 (zero substitution, lfsr_next=16'hB400).
REQ-036 SHALL verify mode=1, gsensor=5'b00101, ready=0, six events -> level=4, overflow=1, and the head is the first sample.
REQ-037 SHALL verify a full FIFO with ready=1 held across an event -> level stays 4, overflow stays 0, and output order is preserved.
REQ-038 SHALL verify rst asserted at cnt=2 -> all outputs at reset values next cycle, and the first tick occurs TICK_DIV cycles after release.
REQ-039 SHALL verify, with ARROW_GEN_REPEAT_FILTER_EN defined, seed=0: the 1st event pushes 1 and the 2nd pushes 2 (repeat of 1 filtered).
